// File: rtl/epp_bus_bridge.sv
// EPP slave to 32-bit pipelined Wishbone master bridge: byte-wide host register file drives bus cycles.
// Optional feature macro: EPP_BUS_AUTO_INC_EN (bus address advances by 4 on every acknowledged transfer).
module epp_bus_bridge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST_SYNC,
    input  logic        EPP_ASTB_IN,
    input  logic        EPP_DSTB_IN,
    input  logic        EPP_WRITE_IN,
    input  logic [7:0]  EPP_DATA_IN,
    output logic [7:0]  EPP_DATA_OUT,
    output logic        EPP_DATA_OE_OUT,
    output logic        EPP_WAIT_OUT,
    output logic        BUS_CYC_OUT,
    output logic        BUS_STB_OUT,
    output logic        BUS_WE_OUT,
    output logic [31:0] BUS_ADR_OUT,
    output logic [3:0]  BUS_SEL_OUT,
    output logic [31:0] BUS_DAT_WR_OUT,
    input  logic [31:0] BUS_DAT_RD_IN,
    input  logic        BUS_ACK_IN,
    input  logic        BUS_STALL_IN
);

    localparam int unsigned EPP_W = 8;
    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_WR, S_ADDR_RD, S_DATA_WR, S_DATA_RD, S_BUS_WAIT, S_HANDSHAKE
    } epp_state_t;

    typedef enum logic [1:0] {B_IDLE, B_REQ, B_ACK} bus_state_t;

    epp_state_t              epp_state_q, epp_state_d;
    bus_state_t              bus_state_q, bus_state_d;
    logic [SYNC_STAGES-1:0]  astb_sync_q, astb_sync_d;
    logic [SYNC_STAGES-1:0]  dstb_sync_q, dstb_sync_d;
    logic [SYNC_STAGES-1:0]  wr_sync_q, wr_sync_d;
    logic [EPP_W-1:0]        ep_addr_q, ep_addr_d;
    logic [ADR_W-1:0]        adr_q, adr_d;
    logic [DAT_W-1:0]        wdata_q, wdata_d;
    logic [DAT_W-1:0]        rdata_q, rdata_d;
    logic [EPP_W-1:0]        ctrl_q, ctrl_d;
    logic                    is_addr_q, is_addr_d;
    logic                    is_read_q, is_read_d;
    logic [EPP_W-1:0]        data_out_q, data_out_d;
    logic                    oe_q, oe_d;
    logic                    wait_q, wait_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    we_q, we_d;
    logic [ADR_W-1:0]        adr_out_q, adr_out_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [DAT_W-1:0]        dat_wr_q, dat_wr_d;

    logic                    astb_s, dstb_s, wr_s;
    logic [3:0]              reg_sel;
    logic [4:0]              byte_bit;
    logic                    start_c;
    logic                    bus_done_c;
    logic [EPP_W-1:0]        rd_mux_c;

    assign astb_s   = astb_sync_q[SYNC_STAGES-1];
    assign dstb_s   = dstb_sync_q[SYNC_STAGES-1];
    assign wr_s     = wr_sync_q[SYNC_STAGES-1];
    assign reg_sel  = ep_addr_q[3:0];
    assign byte_bit = {reg_sel[1:0], 3'b000};
    assign start_c  = (epp_state_q == S_DATA_WR) && (reg_sel == 4'hC);

    // Strobe/direction synchronisers
    always_comb begin
        astb_sync_d = {astb_sync_q[SYNC_STAGES-2:0], EPP_ASTB_IN};
        dstb_sync_d = {dstb_sync_q[SYNC_STAGES-2:0], EPP_DSTB_IN};
        wr_sync_d   = {wr_sync_q[SYNC_STAGES-2:0], EPP_WRITE_IN};
    end

    // Host read-data mux over the register map
    always_comb begin
        rd_mux_c = '0;
        case (reg_sel[3:2])
            2'd0: rd_mux_c = adr_q[byte_bit +: 8];
            2'd1: rd_mux_c = wdata_q[byte_bit +: 8];
            2'd2: rd_mux_c = rdata_q[byte_bit +: 8];
            default: begin
                case (reg_sel[1:0])
                    2'd0:    rd_mux_c = ctrl_q;
                    2'd1:    rd_mux_c = {7'd0, bus_state_q != B_IDLE};
                    default: rd_mux_c = '0;
                endcase
            end
        endcase
    end

    // Wishbone master FSM; outputs frozen at request entry
    always_comb begin
        bus_state_d = bus_state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_out_d   = adr_out_q;
        sel_d       = sel_q;
        dat_wr_d    = dat_wr_q;
        bus_done_c  = 1'b0;
        case (bus_state_q)
            B_IDLE: begin
                if (start_c) begin
                    bus_state_d = B_REQ;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    we_d        = ctrl_q[0];
                    sel_d       = ctrl_q[7:4];
                    adr_out_d   = adr_q;
                    dat_wr_d    = wdata_q;
                end
            end
            B_REQ: begin
                if (!BUS_STALL_IN) begin
                    stb_d = 1'b0;
                    if (BUS_ACK_IN) begin
                        cyc_d       = 1'b0;
                        bus_done_c  = 1'b1;
                        bus_state_d = B_IDLE;
                    end else begin
                        bus_state_d = B_ACK;
                    end
                end
            end
            B_ACK: begin
                if (BUS_ACK_IN) begin
                    cyc_d       = 1'b0;
                    bus_done_c  = 1'b1;
                    bus_state_d = B_IDLE;
                end
            end
            default: begin
                bus_state_d = B_IDLE;
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
            end
        endcase
    end

    // EPP handshake FSM and host-visible registers
    always_comb begin
        epp_state_d = epp_state_q;
        ep_addr_d   = ep_addr_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ctrl_d      = ctrl_q;
        is_addr_d   = is_addr_q;
        is_read_d   = is_read_q;
        data_out_d  = data_out_q;

        if (bus_done_c) begin
            if (!we_q) begin
                rdata_d = BUS_DAT_RD_IN;
            end
`ifdef EPP_BUS_AUTO_INC_EN
            adr_d = adr_q + 32'd4;
`endif
        end

        case (epp_state_q)
            S_IDLE: begin
                if (!astb_s) begin
                    is_addr_d = 1'b1;
                    is_read_d = wr_s;
                    if (wr_s) begin
                        epp_state_d = S_ADDR_RD;
                        data_out_d  = ep_addr_q;
                    end else begin
                        epp_state_d = S_ADDR_WR;
                        ep_addr_d   = EPP_DATA_IN;
                    end
                end else if (!dstb_s) begin
                    is_addr_d = 1'b0;
                    is_read_d = wr_s;
                    if (wr_s) begin
                        epp_state_d = S_DATA_RD;
                        data_out_d  = rd_mux_c;
                    end else begin
                        epp_state_d = S_DATA_WR;
                        case (reg_sel[3:2])
                            2'd0: adr_d[byte_bit +: 8]   = EPP_DATA_IN;
                            2'd1: wdata_d[byte_bit +: 8] = EPP_DATA_IN;
                            2'd3: if (reg_sel[1:0] == 2'd0) ctrl_d = EPP_DATA_IN;
                            default: ;
                        endcase
                    end
                end
            end
            S_ADDR_WR, S_ADDR_RD, S_DATA_RD: epp_state_d = S_HANDSHAKE;
            S_DATA_WR:   epp_state_d = (reg_sel == 4'hC) ? S_BUS_WAIT : S_HANDSHAKE;
            S_BUS_WAIT:  if (bus_done_c) epp_state_d = S_HANDSHAKE;
            S_HANDSHAKE: if (is_addr_q ? astb_s : dstb_s) epp_state_d = S_IDLE;
            default:     epp_state_d = S_IDLE;
        endcase

        wait_d = (epp_state_d == S_HANDSHAKE);
        oe_d   = (epp_state_d == S_HANDSHAKE) && is_read_q;
    end

    always_ff @(posedge CLK) begin
        if (RST_SYNC) begin
            epp_state_q <= S_IDLE;
            bus_state_q <= B_IDLE;
            astb_sync_q <= '1;
            dstb_sync_q <= '1;
            wr_sync_q   <= '1;
            ep_addr_q   <= '0;
            adr_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ctrl_q      <= '0;
            is_addr_q   <= 1'b0;
            is_read_q   <= 1'b0;
            data_out_q  <= '0;
            oe_q        <= 1'b0;
            wait_q      <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_out_q   <= '0;
            sel_q       <= '0;
            dat_wr_q    <= '0;
        end else begin
            epp_state_q <= epp_state_d;
            bus_state_q <= bus_state_d;
            astb_sync_q <= astb_sync_d;
            dstb_sync_q <= dstb_sync_d;
            wr_sync_q   <= wr_sync_d;
            ep_addr_q   <= ep_addr_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ctrl_q      <= ctrl_d;
            is_addr_q   <= is_addr_d;
            is_read_q   <= is_read_d;
            data_out_q  <= data_out_d;
            oe_q        <= oe_d;
            wait_q      <= wait_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_out_q   <= adr_out_d;
            sel_q       <= sel_d;
            dat_wr_q    <= dat_wr_d;
        end
    end

    assign EPP_DATA_OUT    = data_out_q;
    assign EPP_DATA_OE_OUT = oe_q;
    assign EPP_WAIT_OUT    = wait_q;
    assign BUS_CYC_OUT     = cyc_q;
    assign BUS_STB_OUT     = stb_q;
    assign BUS_WE_OUT      = we_q;
    assign BUS_ADR_OUT     = adr_out_q;
    assign BUS_SEL_OUT     = sel_q;
    assign BUS_DAT_WR_OUT  = dat_wr_q;

endmodule

// File: tb/tb_epp_bus_bridge.sv
// Self-checking bench for epp_bus_bridge: EPP host driver, Wishbone slave model, directed vector table.
module tb_epp_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        astb, dstb, wr_n;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        oe, epp_wait;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_wr, dat_rd;
    logic [3:0]  sel;
    logic        ack, stall;

    int total = 0;
    int bad   = 0;

    epp_bus_bridge #(.SYNC_STAGES(2)) dut (
        .CLK(clk), .RST_SYNC(rst),
        .EPP_ASTB_IN(astb), .EPP_DSTB_IN(dstb), .EPP_WRITE_IN(wr_n),
        .EPP_DATA_IN(din), .EPP_DATA_OUT(dout), .EPP_DATA_OE_OUT(oe), .EPP_WAIT_OUT(epp_wait),
        .BUS_CYC_OUT(cyc), .BUS_STB_OUT(stb), .BUS_WE_OUT(we), .BUS_ADR_OUT(adr),
        .BUS_SEL_OUT(sel), .BUS_DAT_WR_OUT(dat_wr), .BUS_DAT_RD_IN(dat_rd),
        .BUS_ACK_IN(ack), .BUS_STALL_IN(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Wishbone slave model state
    int          stall_n   = 0;
    int          ack_delay = 0;
    logic [31:0] slave_rdata = 32'h0;
    int          txn_cnt = 0;
    int          ack_cnt = 0;
    logic [31:0] rec_adr [16];
    logic        rec_we  [16];
    logic [3:0]  rec_sel [16];
    logic [31:0] rec_dat [16];
    int          stb_cnt;
    logic        stb_after, wait_pre, wait_post;

    initial begin
        ack = 1'b0; stall = 1'b0; dat_rd = '0;
        forever begin
            @(negedge clk);
            if (cyc && stb && !rst) begin
                rec_adr[txn_cnt % 16] = adr;
                rec_we[txn_cnt % 16]  = we;
                rec_sel[txn_cnt % 16] = sel;
                rec_dat[txn_cnt % 16] = dat_wr;
                stb_cnt = 1;
                if (stall_n > 0) begin
                    stall = 1'b1;
                    for (int i = 0; i < stall_n; i++) begin
                        @(negedge clk);
                        if (stb && adr == rec_adr[txn_cnt % 16]) stb_cnt++;
                    end
                    stall = 1'b0;
                end
                dat_rd = slave_rdata;
                if (ack_delay == 0) begin
                    ack = 1'b1; ack_cnt++;
                    wait_pre = epp_wait;
                    @(negedge clk);
                    ack = 1'b0;
                    stb_after = stb;
                    wait_post = epp_wait;
                end else begin
                    @(negedge clk);
                    stb_after = stb;
                    for (int i = 1; i < ack_delay && cyc; i++) @(negedge clk);
                    if (cyc) begin
                        ack = 1'b1; ack_cnt++;
                        wait_pre = epp_wait;
                        @(negedge clk);
                        ack = 1'b0;
                        wait_post = epp_wait;
                    end
                end
                txn_cnt++;
            end
        end
    end

    // One complete EPP cycle with bounded waits on WAIT
    task automatic epp_cycle(input bit is_addr, input bit rd, input logic [7:0] wd,
                             output logic [7:0] rdd, output logic oe_seen);
        int n;
        rdd = '0; oe_seen = 1'b0;
        @(negedge clk);
        wr_n = rd; din = wd;
        if (is_addr) astb = 1'b0; else dstb = 1'b0;
        n = 0;
        while (!epp_wait && n < 2000) begin @(negedge clk); n++; end
        if (!epp_wait) begin
            total++; bad++;
            $display("FAIL wait_rise_timeout: got 0 want 1");
        end
        rdd = dout; oe_seen = oe;
        astb = 1'b1; dstb = 1'b1;
        n = 0;
        while ((epp_wait || oe) && n < 100) begin @(negedge clk); n++; end
        if (epp_wait || oe) begin
            total++; bad++;
            $display("FAIL wait_fall_timeout: got %b%b want 00", epp_wait, oe);
        end
        wr_n = 1'b1;
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r; logic o;
        epp_cycle(1'b1, 1'b0, a, r, o);
        epp_cycle(1'b0, 1'b0, d, r, o);
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [7:0] d);
        logic o;
        epp_cycle(1'b1, 1'b0, a, d, o);
        epp_cycle(1'b0, 1'b1, 8'h00, d, o);
        chk("rd_oe", 32'(o), 32'd1);
    endtask

    task automatic set_adr(input logic [31:0] v);
        for (int i = 0; i < 4; i++) reg_wr(8'(i), v[8*i +: 8]);
    endtask

    typedef struct {
        bit         is_addr;
        bit         rd;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [31];

    initial begin
        logic [7:0]  r;
        logic        o;
        int          n, t0;
        logic [31:0] exp2;

        tbl[0]  = '{1, 0, 8'h0D, 8'h00};
        tbl[1]  = '{0, 1, 8'h00, 8'h00};
        tbl[2]  = '{1, 0, 8'h00, 8'h00};  tbl[3]  = '{0, 0, 8'h00, 8'h00};
        tbl[4]  = '{1, 0, 8'h01, 8'h00};  tbl[5]  = '{0, 0, 8'h10, 8'h00};
        tbl[6]  = '{1, 0, 8'h02, 8'h00};  tbl[7]  = '{0, 0, 8'h00, 8'h00};
        tbl[8]  = '{1, 0, 8'h03, 8'h00};  tbl[9]  = '{0, 0, 8'h00, 8'h00};
        tbl[10] = '{1, 0, 8'h04, 8'h00};  tbl[11] = '{0, 0, 8'hEF, 8'h00};
        tbl[12] = '{1, 0, 8'h05, 8'h00};  tbl[13] = '{0, 0, 8'hBE, 8'h00};
        tbl[14] = '{1, 0, 8'h06, 8'h00};  tbl[15] = '{0, 0, 8'hAD, 8'h00};
        tbl[16] = '{1, 0, 8'h07, 8'h00};  tbl[17] = '{0, 0, 8'hDE, 8'h00};
        tbl[18] = '{1, 1, 8'h00, 8'h07};
        tbl[19] = '{0, 1, 8'h00, 8'hDE};
        tbl[20] = '{1, 0, 8'h05, 8'h00};  tbl[21] = '{0, 1, 8'h00, 8'hBE};
        tbl[22] = '{1, 0, 8'h01, 8'h00};  tbl[23] = '{0, 1, 8'h00, 8'h10};
        tbl[24] = '{1, 0, 8'h0E, 8'h00};  tbl[25] = '{0, 0, 8'h55, 8'h00};
        tbl[26] = '{0, 1, 8'h00, 8'h00};
        tbl[27] = '{1, 0, 8'h1C, 8'h00};  tbl[28] = '{0, 1, 8'h00, 8'h00};
        tbl[29] = '{1, 0, 8'h08, 8'h00};  tbl[30] = '{0, 1, 8'h00, 8'h00};

        rst = 1'b1; astb = 1'b1; dstb = 1'b1; wr_n = 1'b1; din = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_dat_wr", dat_wr, 32'd0);
        chk("rst_wait", 32'(epp_wait), 32'd0);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);

        for (int i = 0; i < 31; i++) begin
            epp_cycle(tbl[i].is_addr, tbl[i].rd, tbl[i].wd, r, o);
            if (tbl[i].rd) begin
                chk($sformatf("tbl%0d_data", i), 32'(r), 32'(tbl[i].exp));
                chk($sformatf("tbl%0d_oe", i), 32'(o), 32'd1);
            end
        end

        // Bus write, ACK three cycles into the data phase
        ack_delay = 3; stall_n = 0;
        t0 = txn_cnt;
        reg_wr(8'h0C, 8'hF1);
        chk("wr_txn_cnt", 32'(txn_cnt - t0), 32'd1);
        chk("wr_adr", rec_adr[t0 % 16], 32'h0000_1000);
        chk("wr_we", 32'(rec_we[t0 % 16]), 32'd1);
        chk("wr_sel", 32'(rec_sel[t0 % 16]), 32'hF);
        chk("wr_dat", rec_dat[t0 % 16], 32'hDEAD_BEEF);
        chk("wr_stb_drop", 32'(stb_after), 32'd0);
        chk("wr_wait_before_ack", 32'(wait_pre), 32'd0);
        chk("wr_wait_after_ack", 32'(wait_post), 32'd1);
        reg_rd(8'h0C, r);
        chk("ctrl_readback", 32'(r), 32'hF1);

        // Bus read
        set_adr(32'h0000_1000);
        slave_rdata = 32'hCAFE_F00D; ack_delay = 2;
        t0 = txn_cnt;
        reg_wr(8'h0C, 8'hF0);
        chk("rd_adr", rec_adr[t0 % 16], 32'h0000_1000);
        chk("rd_we", 32'(rec_we[t0 % 16]), 32'd0);
        reg_rd(8'h08, r); chk("rdata_b0", 32'(r), 32'h0D);
        reg_rd(8'h09, r); chk("rdata_b1", 32'(r), 32'hF0);
        reg_rd(8'h0A, r); chk("rdata_b2", 32'(r), 32'hFE);
        reg_rd(8'h0B, r); chk("rdata_b3", 32'(r), 32'hCA);
        reg_rd(8'h0D, r); chk("status_idle", 32'(r), 32'h00);

        // Stall for five cycles, ACK together with acceptance
        set_adr(32'h0000_2000);
        stall_n = 5; ack_delay = 0;
        t0 = txn_cnt;
        reg_wr(8'h0C, 8'hF1);
        repeat (10) @(negedge clk);
        chk("stall_txn_cnt", 32'(txn_cnt - t0), 32'd1);
        chk("stall_stb_cycles", 32'(stb_cnt), 32'd6);
        chk("stall_adr", rec_adr[t0 % 16], 32'h0000_2000);
        chk("stall_stb_drop", 32'(stb_after), 32'd0);
        chk("stall_cyc_drop", 32'(cyc), 32'd0);
        stall_n = 0;

        // Address wrap on back-to-back transfers
        set_adr(32'hFFFF_FFFC);
        t0 = txn_cnt;
        reg_wr(8'h0C, 8'hF1);
        reg_wr(8'h0C, 8'hF1);
`ifdef EPP_BUS_AUTO_INC_EN
        exp2 = 32'h0000_0000;
`else
        exp2 = 32'hFFFF_FFFC;
`endif
        chk("wrap_first_adr", rec_adr[t0 % 16], 32'hFFFF_FFFC);
        chk("wrap_second_adr", rec_adr[(t0 + 1) % 16], exp2);
        reg_rd(8'h00, r);
        chk("wrap_adr_b0", 32'(r), 32'(exp2[7:0] + 8'h00) + ((exp2 == 32'h0) ? 32'h4 : 32'h0));

        // Reset while the slave holds off ACK
        ack_delay = 40;
        epp_cycle(1'b1, 1'b0, 8'h0C, r, o);
        @(negedge clk);
        wr_n = 1'b0; din = 8'hF1; dstb = 1'b0;
        n = 0;
        while (!(cyc && !stb) && n < 200) begin @(negedge clk); n++; end
        chk("rst_mid_in_ack_phase", 32'(cyc && !stb), 32'd1);
        t0 = ack_cnt;
        rst = 1'b1; dstb = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_cyc", 32'(cyc), 32'd0);
        chk("rst_mid_stb", 32'(stb), 32'd0);
        chk("rst_mid_wait", 32'(epp_wait), 32'd0);
        chk("rst_mid_oe", 32'(oe), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mid_no_ack", 32'(ack_cnt - t0), 32'd0);
        chk("rst_mid_cyc_later", 32'(cyc), 32'd0);

        ack_delay = 1;
        set_adr(32'h0000_3000);
        t0 = txn_cnt;
        reg_wr(8'h0C, 8'hF1);
        chk("post_rst_txn_cnt", 32'(txn_cnt - t0), 32'd1);
        chk("post_rst_adr", rec_adr[t0 % 16], 32'h0000_3000);
        chk("post_rst_dat", rec_dat[t0 % 16], 32'h0000_0000);
        reg_rd(8'h0C, r);
        chk("post_rst_ctrl", 32'(r), 32'hF1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/epp_bus_bridge.md
# epp_bus_bridge

EPP slave that terminates the host USB/EPP link (ASTB/DSTB/WAIT, 8-bit data) and converts byte-wide register accesses into 32-bit pipelined Wishbone master transactions on the FPGA bus. It sits between the board-level EPP pins (driven by the EPP master BFM in simulation) and the bus fabric inside `fpga_bus_top`. Its purpose is to let the host peek and poke any bus address, for example VGA framebuffer memory. Pad tristating is done above this block, so the data bus is split into in, out and output-enable.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops on each asynchronous EPP input (ASTB, DSTB, WRITE); minimum 2.

Ports:
- `CLK` in 1: bus clock.
- `RST_SYNC` in 1: reset, synchronous and active-high.
- `EPP_ASTB_IN` in 1: address strobe, active low, asynchronous.
- `EPP_DSTB_IN` in 1: data strobe, active low, asynchronous.
- `EPP_WRITE_IN` in 1: 0 = host write, 1 = host read.
- `EPP_DATA_IN` in 8: host data, sampled on strobe detection.
- `EPP_DATA_OUT` out 8: read data to the pad.
- `EPP_DATA_OE_OUT` out 1: pad drive enable.
- `EPP_WAIT_OUT` out 1: high means the cycle is complete.
- `BUS_CYC_OUT`, `BUS_STB_OUT`, `BUS_WE_OUT` out 1 each: Wishbone master controls.
- `BUS_ADR_OUT` out 32: byte address.
- `BUS_SEL_OUT` out 4: byte lane selects.
- `BUS_DAT_WR_OUT` out 32: write data.
- `BUS_DAT_RD_IN` in 32: read data.
- `BUS_ACK_IN` in 1: transfer acknowledge.
- `BUS_STALL_IN` in 1: pipelined stall.

## Operation
Register map. Only the low 4 bits of the 8-bit EPP address register are decoded. All multi-byte registers are LSB first.
- 0x0–0x3: ADR, read/write.
- 0x4–0x7: WDATA, read/write.
- 0x8–0xB: RDATA, read-only.
- 0xC: CTRL. A write starts a bus transaction, with bit0 = WE and bits[7:4] = SEL. Reads return the last CTRL value.
- 0xD: STATUS, read-only. bit0 = bus busy.
- 0xE–0xF: read 0x00; writes are ignored.

EPP FSM:
- IDLE:
  - Synchronised ASTB low with WRITE low → ADDR_WR. Capture `EPP_DATA_IN` into the address register.
  - Synchronised ASTB low with WRITE high → ADDR_RD. Drive the address register onto `EPP_DATA_OUT`.
  - Synchronised DSTB low → DATA_WR or DATA_RD, with a register write or read at the current address.
  - If ASTB and DSTB are both low, ASTB wins.
- ADDR_* and DATA_* → HANDSHAKE, except DATA_WR to CTRL, which goes to BUS_WAIT.
- BUS_WAIT: hold `EPP_WAIT_OUT` low until the bus FSM returns to idle, then → HANDSHAKE.
- HANDSHAKE: `EPP_WAIT_OUT`=1 and, for reads, `EPP_DATA_OE_OUT`=1. Stay until the active synchronised strobe goes high, then drop WAIT and OE and → IDLE.

Bus FSM:
- B_IDLE → B_REQ on a CTRL write. `BUS_CYC_OUT`=`BUS_STB_OUT`=1, with ADR, WDATA, WE and SEL from the registers.
- B_REQ: while `BUS_STALL_IN`=1, hold STB and all outputs stable. On STB & !STALL → B_ACK with STB=0 and CYC held at 1.
- B_ACK: on `BUS_ACK_IN` with WE=0, latch `BUS_DAT_RD_IN` into RDATA. On `BUS_ACK_IN` in either case, CYC=0 and → B_IDLE.
- ACK arriving in the same cycle as the STB acceptance completes the transfer; the FSM goes directly to B_IDLE.
- `BUS_ACK_IN` outside B_REQ/B_ACK is ignored.
- There is no bus timeout. The host stalls in BUS_WAIT indefinitely.

Registers written while the bus is busy:
- A CTRL write is accepted only from B_IDLE. This is guaranteed because the previous CTRL cycle is stalled in BUS_WAIT.
- ADR and WDATA writes during a transfer update the registers but not the in-flight outputs, which are latched at B_REQ entry.

## Timing
- Strobe detection takes `SYNC_STAGES`+1 cycles after the pin falls. WAIT rises 1 cycle after detection for non-CTRL cycles.
- For a CTRL write, WAIT rises 1 cycle after the cycle in which ACK is accepted.
- WAIT and OE fall `SYNC_STAGES`+1 cycles after the strobe pin rises.
- `EPP_DATA_OUT` is registered and valid in the cycle before OE rises.
- Bus latency: CYC/STB assert 1 cycle after CTRL capture.
- Reset values: WAIT, OE, CYC, STB and WE are 0. DATA_OUT, ADR, SEL, DAT_WR, all internal registers, and the synchroniser flops (which reset to 1, i.e. strobes inactive) take their reset values.
- Reset mid-transaction: all FSMs return to IDLE/B_IDLE in the next cycle. CYC and STB drop immediately, and no ACK is expected afterwards.

## Configuration
- `EPP_BUS_AUTO_INC_EN` defined: on every bus ACK, ADR += 4, wrapping modulo 2^32. The next CTRL write therefore accesses the next word without re-writing ADR.
- Not defined: ADR changes only on host writes to 0x0–0x3.

## Test plan
- Reset, then idle for 20 cycles → all bus outputs are 0, WAIT=0 and OE=0.
- Address write 0x0D then data read → returns 0x00. Address write 0x0C with data 0xF1 → bus write, SEL=0xF. With ADR=0x00001000, WDATA=0xDEADBEEF and ACK after 3 cycles, host WAIT rises only after ACK.
- CTRL 0xF0 read of 0x00001000 with slave returning 0xCAFEF00D → RDATA bytes 0x0D, 0xF0, 0xFE, 0xCA read at 0x8–0xB.
- `BUS_STALL_IN` held high for 5 cycles → STB and ADR stable for 6 cycles, exactly one transfer.
- ADR=0xFFFFFFFC, two CTRL writes with `EPP_BUS_AUTO_INC_EN` → second access at 0x00000000. Without the macro, both accesses go to 0xFFFFFFFC.
- `RST_SYNC` pulsed during B_ACK → CYC=0 the next cycle and the EPP FSM is in IDLE. A subsequent transaction completes normally.
